// File: rtl/dma_bus_initiator_if.sv
// Purpose: bundles the sequencer handshake and 68030-style host bus signals of the DMA bus initiator.
// Latency: none; plain wires.
// Backpressure: the sequencer waits for CYCLE_ACK/CYCLE_DONE; the host slave stalls via DSACK_/BERR_.
// Ports (master view):
//   in : OWN, CYCLE_REQ, CYCLE_RW, ADDR_IN, WDATA_IN, DATA_BUS_IN, DSACK_, BERR_
//   out: CYCLE_ACK, CYCLE_DONE, CYCLE_ERR, RDATA, PORT16, AS_, DS_, R_W,
//        ADDR_OUT, DATA_OUT, DATA_OE, BUS_ACTIVE
interface dma_bus_initiator_if;
  // sequencer side
  logic        OWN;
  logic        CYCLE_REQ;
  logic        CYCLE_RW;
  logic [31:0] ADDR_IN;
  logic [31:0] WDATA_IN;
  logic        CYCLE_ACK;
  logic        CYCLE_DONE;
  logic        CYCLE_ERR;
  logic [31:0] RDATA;
  logic        PORT16;
  // host bus side
  logic [31:0] DATA_BUS_IN;
  logic [1:0]  DSACK_;
  logic        BERR_;
  logic        AS_;
  logic        DS_;
  logic        R_W;
  logic [31:0] ADDR_OUT;
  logic [31:0] DATA_OUT;
  logic        DATA_OE;
  logic        BUS_ACTIVE;

  modport master (
    input  OWN, CYCLE_REQ, CYCLE_RW, ADDR_IN, WDATA_IN,
    input  DATA_BUS_IN, DSACK_, BERR_,
    output CYCLE_ACK, CYCLE_DONE, CYCLE_ERR, RDATA, PORT16,
    output AS_, DS_, R_W, ADDR_OUT, DATA_OUT, DATA_OE, BUS_ACTIVE
  );

  modport slave (
    output OWN, CYCLE_REQ, CYCLE_RW, ADDR_IN, WDATA_IN,
    output DATA_BUS_IN, DSACK_, BERR_,
    input  CYCLE_ACK, CYCLE_DONE, CYCLE_ERR, RDATA, PORT16,
    input  AS_, DS_, R_W, ADDR_OUT, DATA_OUT, DATA_OE, BUS_ACTIVE
  );
endinterface

// File: rtl/dma_bus_initiator.sv
// Purpose: bus-master side of a 68030-style asynchronous bus cycle for DMA transfers.
// Latency: ACK 1 clk after REQ sampled; DONE 5 clks after REQ with zero wait states; 7 clks min spacing.
// Backpressure: REQ held off while OWN=0; slave stretches the cycle via DSACK_/BERR_, bounded by TIMEOUT.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : master modport carrying sequencer handshake (REQ/ACK/DONE/ERR/RDATA/PORT16)
//               and host bus signals (AS_/DS_/R_W/ADDR_OUT/DATA_OUT/DATA_OE/BUS_ACTIVE, DSACK_/BERR_/DATA_BUS_IN)
module dma_bus_initiator #(
  parameter int TIMEOUT = 64,  // WAIT cycles before the cycle aborts (2..255)
  parameter int TO_W    = 8    // timeout counter width, must hold TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST,
  dma_bus_initiator_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_STRB,
    S_WAIT,
    S_TERM,
    S_NEG,
    S_ERR,
    S_REC
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rw_q, rw_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            port16_q, port16_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            as_n_q, as_n_d;
  logic            ds_n_q, ds_n_d;
  logic            r_w_q, r_w_d;
  logic            data_oe_q, data_oe_d;
  logic            bus_active_q, bus_active_d;

  logic term_seen;
  logic berr_seen;

  assign term_seen = (bus.DSACK_ != 2'b11);
  assign berr_seen = ~bus.BERR_;

  // Next state, captured request and counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    port16_d = port16_q;
    ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.CYCLE_REQ && bus.OWN) begin
          rw_d     = bus.CYCLE_RW;
          addr_d   = bus.ADDR_IN;
          wdata_d  = bus.WDATA_IN;
          port16_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: state_d = S_STRB;
      S_STRB: state_d = S_WAIT;
      S_WAIT: begin
        // BERR_ beats DSACK_ when both arrive together.
        if (berr_seen) begin
          state_d = S_ERR;
        end else if (term_seen) begin
          port16_d = (bus.DSACK_ == 2'b01);
          state_d  = S_TERM;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TERM: begin
        // Slave data is stable one clock after termination was seen.
        if (rw_q) begin
          rdata_d = bus.DATA_BUS_IN;
        end
        state_d = S_NEG;
      end
      S_NEG:  state_d = S_REC;
      S_ERR:  state_d = S_REC;
      S_REC: begin
        // Do not start another cycle while the slave still drives termination.
        if (!term_seen && !berr_seen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so every pin comes from a flop
  // yet lines up with the state it belongs to.
  always_comb begin
    as_n_d       = 1'b1;
    ds_n_d       = 1'b1;
    r_w_d        = 1'b1;
    data_oe_d    = 1'b0;
    bus_active_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_d)
      S_ADDR: begin
        r_w_d        = rw_d;
        bus_active_d = 1'b1;
        data_oe_d    = ~rw_d;
      end
      S_STRB: begin
        r_w_d        = rw_d;
        bus_active_d = 1'b1;
        data_oe_d    = ~rw_d;
        as_n_d       = 1'b0;
        // Reads assert DS_ with AS_; writes wait one clock for data setup.
        ds_n_d       = ~rw_d;
      end
      S_WAIT, S_TERM: begin
        r_w_d        = rw_d;
        bus_active_d = 1'b1;
        data_oe_d    = ~rw_d;
        as_n_d       = 1'b0;
        ds_n_d       = 1'b0;
      end
      S_NEG: begin
        r_w_d        = rw_d;
        bus_active_d = 1'b1;
        // Write data held one clock past strobe negation.
        data_oe_d    = ~rw_d;
        done_d       = 1'b1;
      end
      S_ERR: begin
        r_w_d        = rw_d;
        bus_active_d = 1'b1;
        done_d       = 1'b1;
        err_d        = 1'b1;
      end
      S_REC: begin
        bus_active_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      port16_q     <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      as_n_q       <= 1'b1;
      ds_n_q       <= 1'b1;
      r_w_q        <= 1'b1;
      data_oe_q    <= 1'b0;
      bus_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      port16_q     <= port16_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      as_n_q       <= as_n_d;
      ds_n_q       <= ds_n_d;
      r_w_q        <= r_w_d;
      data_oe_q    <= data_oe_d;
      bus_active_q <= bus_active_d;
    end
  end

  assign bus.CYCLE_ACK  = ack_q;
  assign bus.CYCLE_DONE = done_q;
  assign bus.CYCLE_ERR  = err_q;
  assign bus.RDATA      = rdata_q;
  assign bus.PORT16     = port16_q;
  assign bus.AS_        = as_n_q;
  assign bus.DS_        = ds_n_q;
  assign bus.R_W        = r_w_q;
  assign bus.ADDR_OUT   = addr_q;
  assign bus.DATA_OUT   = wdata_q;
  assign bus.DATA_OE    = data_oe_q;
  assign bus.BUS_ACTIVE = bus_active_q;

endmodule

// File: tb/tb_dma_bus_initiator.sv
// Purpose: randomized self-checking bench for dma_bus_initiator against a cycle-timeline model.
// Latency: model predicts each output per clock from the transaction's termination point.
// Backpressure: slave response (wait states, hold, BERR_, timeout) and OWN hold-off are randomized.
module tb_dma_bus_initiator;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_bus_initiator_if bus();

  dma_bus_initiator #(.TIMEOUT(T), .TO_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.OWN         = 1'b1;
    bus.CYCLE_REQ   = 1'b0;
    bus.CYCLE_RW    = 1'b1;
    bus.ADDR_IN     = $urandom;
    bus.WDATA_IN    = $urandom;
    bus.DATA_BUS_IN = $urandom;
    bus.DSACK_      = 2'b11;
    bus.BERR_       = 1'b1;
  endtask

  // kind: 0 = DSACK_ termination, 1 = BERR_, 2 = no response (timeout)
  // k    : WAIT cycle index at which the slave responds
  // hold : extra clocks the slave keeps driving termination after TERM/ERR point
  // data : write data, or slave read data for reads
  task automatic run_cycle(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                           input int kind, input int k, input logic [1:0] dsv,
                           input int hold, input int own_delay);
    int  d, r, idle_c, end_strb;
    bit  ok, pres, oe_exp;
    ok       = (kind == 0);
    d        = (kind == 0) ? 5 + k : (kind == 1) ? 4 + k : 3 + T;
    r        = (kind == 2) ? 0 : 4 + k + hold;
    idle_c   = ((d + 1 > r) ? d + 1 : r) + 1;
    end_strb = ok ? 5 + k : d;

    for (int p = 0; p < own_delay; p++) begin
      @(posedge clk); #1;
      idle_inputs();
      bus.OWN       = 1'b0;
      bus.CYCLE_REQ = 1'b1;
      @(negedge clk);
      cyc = -1;
      check("ack_held_off", 32'(bus.CYCLE_ACK), 32'h0);
    end

    @(posedge clk); #1;
    idle_inputs();
    bus.CYCLE_REQ = 1'b1;
    bus.CYCLE_RW  = rw;
    bus.ADDR_IN   = addr;
    bus.WDATA_IN  = data;
    @(negedge clk);

    for (int c = 1; c <= idle_c; c++) begin
      @(posedge clk); #1;
      bus.CYCLE_REQ   = 1'b0;
      bus.ADDR_IN     = $urandom;
      bus.WDATA_IN    = $urandom;
      bus.CYCLE_RW    = 1'($urandom);
      bus.OWN         = 1'($urandom);
      pres            = (kind != 2) && (c >= 3 + k) && (c < r);
      bus.DSACK_      = pres ? dsv : 2'b11;
      bus.BERR_       = !(pres && kind == 1);
      bus.DATA_BUS_IN = (c == 4 + k && ok && rw) ? data : $urandom;
      @(negedge clk);
      cyc    = c;
      oe_exp = !rw && (ok ? (c <= d) : (c < d));
      check("ack",        32'(bus.CYCLE_ACK),  32'(c == 1));
      check("bus_active", 32'(bus.BUS_ACTIVE), 32'(c < idle_c));
      check("as_n",       32'(bus.AS_),        32'(!(c >= 2 && c < end_strb)));
      check("ds_n",       32'(bus.DS_),        32'(!((rw ? c >= 2 : c >= 3) && c < end_strb)));
      check("r_w",        32'(bus.R_W),        32'((c <= d) ? rw : 1'b1));
      check("data_oe",    32'(bus.DATA_OE),    32'(oe_exp));
      check("done",       32'(bus.CYCLE_DONE), 32'(c == d));
      if (c < idle_c) check("addr_out", bus.ADDR_OUT, addr);
      if (oe_exp)     check("data_out", bus.DATA_OUT, data);
      if (c == d) begin
        if (ok && rw) model_rdata = data;
        check("err",    32'(bus.CYCLE_ERR), 32'(!ok));
        check("port16", 32'(bus.PORT16),    32'(ok && dsv == 2'b01));
        check("rdata",  bus.RDATA,          model_rdata);
      end
      if (c == idle_c) check("rdata_hold", bus.RDATA, model_rdata);
    end
  endtask

  // Read with no response, reset asserted in the second WAIT clock.
  task automatic reset_abort();
    bit saw_done;
    saw_done = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    bus.CYCLE_REQ = 1'b1;
    bus.ADDR_IN   = 32'h00F00100;
    @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      bus.CYCLE_REQ = 1'b0;
      rst           = (c == 4);
      @(negedge clk);
      cyc = c;
      if (bus.CYCLE_DONE) saw_done = 1'b1;
      if (c == 5) begin
        check("rst_as_n",       32'(bus.AS_),        32'h1);
        check("rst_ds_n",       32'(bus.DS_),        32'h1);
        check("rst_bus_active", 32'(bus.BUS_ACTIVE), 32'h0);
        check("rst_rdata",      bus.RDATA,           32'h0);
      end
    end
    model_rdata = 32'h0;
    check("rst_no_done", 32'(saw_done), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.OWN       = 1'b0;
    bus.CYCLE_REQ = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_as_n",       32'(bus.AS_),        32'h1);
    check("reset_ds_n",       32'(bus.DS_),        32'h1);
    check("reset_r_w",        32'(bus.R_W),        32'h1);
    check("reset_data_oe",    32'(bus.DATA_OE),    32'h0);
    check("reset_bus_active", 32'(bus.BUS_ACTIVE), 32'h0);
    check("reset_ack",        32'(bus.CYCLE_ACK),  32'h0);
    check("reset_done",       32'(bus.CYCLE_DONE), 32'h0);
    check("reset_err",        32'(bus.CYCLE_ERR),  32'h0);
    check("reset_port16",     32'(bus.PORT16),     32'h0);
    check("reset_addr_out",   bus.ADDR_OUT,        32'h0);
    check("reset_data_out",   bus.DATA_OUT,        32'h0);
    check("reset_rdata",      bus.RDATA,           32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    // zero-wait read, DSACK_ released in cycle 6
    run_cycle(1'b1, 32'h00F00010, 32'hDEADBEEF, 0, 0, 2'b00, 2, 0);
    // write with three wait states
    run_cycle(1'b0, 32'h00F00020, 32'h12345678, 0, 3, 2'b00, 1, 0);
    // 16-bit port answer
    run_cycle(1'b1, 32'h00F00030, 32'hCAFE5555, 0, 1, 2'b01, 1, 0);
    // BERR_ with DSACK_ in same WAIT clock, BERR_ held 4 more clocks
    run_cycle(1'b1, 32'h00F00040, 32'hA5A5A5A5, 1, 0, 2'b00, 4, 0);
    // no response: timeout
    run_cycle(1'b1, 32'h00F00050, 32'h0BADF00D, 2, 0, 2'b11, 0, 0);
    // reset during WAIT
    reset_abort();
    // request held off by OWN for 10 clocks
    run_cycle(1'b1, 32'h00F00060, 32'h13579BDF, 0, 0, 2'b00, 1, 10);

    for (int n = 0; n < 40; n++) begin
      int          kind, k;
      logic [1:0]  dsv;
      logic [31:0] a;
      kind = $urandom_range(0, 5);
      kind = (kind < 4) ? 0 : (kind == 4) ? 1 : 2;
      k    = $urandom_range(0, 6);
      dsv  = (kind == 0) ? 2'($urandom_range(0, 2)) : 2'($urandom);
      a    = $urandom;
      a[1:0] = 2'b00;
      run_cycle(1'($urandom), a, $urandom, kind, k, dsv,
                $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dma_bus_initiator.md
Name: dma_bus_initiator

Overview:
- Bus-master side of the 68030-style asynchronous bus cycle: drives AS_, DS_, R_W and address/data for DMA transfers.
- Waits for DSACK_ or BERR_ termination from the addressed slave.
- Sits between the DMA FIFO/sequencer (request/ack handshake) and the host bus.
- Active only while the arbiter grants ownership (OWN).

Parameters:
- TIMEOUT, 64: WAIT-state cycles before the cycle aborts with an error (2..255).
- TO_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  synchronous reset, active-high
- OWN  input  1  bus granted to DMAC; sampled only in IDLE
- CYCLE_REQ  input  1  sequencer requests one 32-bit bus cycle
- CYCLE_RW  input  1  1 = read from bus, 0 = write to bus
- ADDR_IN  input  32  cycle address, longword aligned
- WDATA_IN  input  32  write data
- CYCLE_ACK  output  1  one-cycle pulse: request captured
- CYCLE_DONE  output  1  one-cycle pulse: cycle finished (ok or error)
- CYCLE_ERR  output  1  valid with CYCLE_DONE; 1 = BERR_ or timeout
- RDATA  output  32  read data; valid from CYCLE_DONE until next CYCLE_ACK
- PORT16  output  1  valid with CYCLE_DONE; 1 = slave answered 16-bit (DSACK_=2'b01)
- DATA_BUS_IN  input  32  bus data, synchronous to CLK
- DSACK_  input  2  slave termination, active-low, synchronous to CLK
- BERR_  input  1  bus error, active-low, synchronous to CLK
- AS_  output  1  address strobe, active-low
- DS_  output  1  data strobe, active-low
- R_W  output  1  1 = read
- ADDR_OUT  output  32  bus address
- DATA_OUT  output  32  bus write data
- DATA_OE  output  1  enable for the DATA_OUT drivers
- BUS_ACTIVE  output  1  high from S_ADDR through S_REC (address buffers enable)

Behaviour:
- All outputs are registered.
- Reset values: AS_=1, DS_=1, R_W=1, DATA_OE=0, BUS_ACTIVE=0, CYCLE_ACK=0, CYCLE_DONE=0, CYCLE_ERR=0, PORT16=0, ADDR_OUT=0, DATA_OUT=0, RDATA=0; state IDLE; timeout counter 0.
- States, one per cycle unless noted:
  - IDLE:
    - Strobes negated.
    - On CYCLE_REQ & OWN: capture ADDR_IN, WDATA_IN and CYCLE_RW; pulse CYCLE_ACK; go to S_ADDR.
    - If OWN=0, REQ is held off; no ACK.
  - S_ADDR:
    - ADDR_OUT and R_W valid; BUS_ACTIVE=1.
    - For a write, DATA_OE=1 and DATA_OUT is driven.
  - S_STRB:
    - AS_=0.
    - For a read, DS_=0 in this same cycle.
  - S_WAIT:
    - AS_=0 and DS_=0; for a write, DS_ first asserts here.
    - Termination is checked in this priority order:
      1. BERR_=0: go to S_ERR.
      2. DSACK_!=2'b11: record PORT16 and go to S_TERM.
      3. Counter reaches TIMEOUT-1: go to S_ERR.
      4. Otherwise increment the counter and stay.
    - BERR_ together with DSACK_ is treated as an error; BERR_ wins.
  - S_TERM:
    - Strobes still asserted.
    - For a read, DATA_BUS_IN is latched into RDATA at the end of this cycle.
  - S_NEG:
    - AS_=1, DS_=1.
    - For a write, DATA_OE stays 1 for this cycle (hold time).
    - CYCLE_DONE=1, CYCLE_ERR=0.
  - S_ERR:
    - AS_=1, DS_=1, DATA_OE=0.
    - CYCLE_DONE=1, CYCLE_ERR=1; RDATA unchanged.
  - S_REC:
    - DATA_OE=0, R_W=1.
    - Stay until DSACK_=2'b11 and BERR_=1, then go to IDLE.
    - No new strobe may assert while the slave still drives termination.
- Latency, read with DSACK_ low in the first WAIT cycle (REQ sampled at end of cycle 0):
  - S_ADDR in cycle 1, AS_ low in cycle 2, DSACK_ sampled at end of cycle 3.
  - RDATA latched at end of cycle 4; CYCLE_DONE in cycle 5.
  - IDLE in cycle 7 if DSACK_ has negated in cycle 6.
- Minimum cycle-to-cycle spacing is 7 clocks.
- The timeout counter clears in IDLE; it counts only in S_WAIT.
- OWN dropping mid-cycle is ignored; the cycle always runs to S_REC. The arbiter must not revoke during BUS_ACTIVE.
- A CYCLE_REQ held high after CYCLE_ACK is treated as a new request once back in IDLE.
- Synchronous RST in any state: next edge forces IDLE and negates all strobes. No CYCLE_DONE is issued for the aborted cycle.

Test Plan:
- Read, zero wait: ADDR_IN=0x00F00010, RW=1; slave pulls DSACK_=00 in first S_WAIT cycle with DATA_BUS_IN=0xDEADBEEF -> AS_ low in cycle 2, CYCLE_DONE in cycle 5, RDATA=0xDEADBEEF, CYCLE_ERR=0, PORT16=0.
- Write, 3 wait states: WDATA_IN=0x12345678 -> DS_ asserts one cycle after AS_; DATA_OE high from S_ADDR through S_NEG; DATA_OUT=0x12345678; CYCLE_DONE 3 cycles later than zero-wait.
- 16-bit port: DSACK_=01 -> PORT16=1 with CYCLE_DONE, CYCLE_ERR=0.
- Bus error: BERR_=0 and DSACK_=00 in the same WAIT cycle -> S_ERR, CYCLE_ERR=1, RDATA unchanged. Hold BERR_ low 4 more cycles -> stays in S_REC; IDLE one cycle after BERR_ negates.
- Timeout: TIMEOUT=8, no response -> exactly 8 S_WAIT cycles, then CYCLE_DONE with CYCLE_ERR=1 and AS_ negated.
- Reset/ownership: RST pulsed during S_WAIT -> AS_=DS_=1 and IDLE next edge, no CYCLE_DONE. CYCLE_REQ with OWN=0 for 10 cycles -> no CYCLE_ACK; OWN rises -> CYCLE_ACK next edge.
